simd_mac_unit: RTL



---
 rtl/simd_mac_pkg.sv | 47 ++++
 rtl/simd_mac_lane.sv | 29 ++
 rtl/simd_mac_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/simd_mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : simd_mac_pkg                                           |
// | Description : Shared types and sizing helpers for the SIMD lane      |
// |               multiply / multiply-accumulate unit.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package simd_mac_pkg;

   // Scoreboard tag width used when the integrator does not override it
   // (matches the CVA6 default).
   localparam int unsigned TRANS_ID_BITS_DEFAULT = 3;

   typedef enum logic [2:0] {
      SMULL   = 3'd0,
      UMULL   = 3'd1,
      SMULH   = 3'd2,
      UMULH   = 3'd3,
      SMAQA   = 3'd4,
      UMAQA   = 3'd5,
      SMAQASU = 3'd6
   } simd_mac_op_t;

   // Decoded operation, produced in stage 0 and carried down the pipe.
   typedef struct packed {
      logic legal;     // op_i was one of the defined encodings
      logic mac;       // dot-product plus accumulator
      logic high;      // packed products of the upper lane half
      logic a_signed;  // treat lane operand a as signed
      logic b_signed;  // treat lane operand b as signed
   } simd_mac_ctrl_t;

   // Number of lanes an XLEN operand splits into.
   function automatic int unsigned lane_count(input int unsigned xlen,
                                              input int unsigned lane_w);
      return xlen / lane_w;
   endfunction

   // Width at which the lane products are summed: product width, plus
   // carry growth over all lanes, plus one bit of sign headroom.
   function automatic int unsigned sum_width(input int unsigned lane_w,
                                             input int unsigned lanes);
      return 2 * lane_w + $clog2(lanes) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/simd_mac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : simd_mac_lane                                          |
// | Description : One LANE_W x LANE_W multiplier with independent        |
// |               signed/unsigned selection for each operand.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module simd_mac_lane #(
   parameter int unsigned LANE_W = 8
) (
   input  logic [LANE_W-1:0]   a,
   input  logic [LANE_W-1:0]   b,
   input  logic                a_signed,
   input  logic                b_signed,
   output logic [2*LANE_W-1:0] product
);

   // Both operands are widened to the product width; a signed x signed
   // multiply at that width yields the exact product for every mix of
   // signedness because the true result always fits in 2*LANE_W bits.
   logic signed [2*LANE_W-1:0] a_ext;
   logic signed [2*LANE_W-1:0] b_ext;

   assign a_ext   = {{LANE_W{a_signed & a[LANE_W-1]}}, a};
   assign b_ext   = {{LANE_W{b_signed & b[LANE_W-1]}}, b};
   assign product = a_ext * b_ext;

endmodule
`default_nettype wire

// File: rtl/simd_mac_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : simd_mac_unit                                          |
// | Description : Pipelined SIMD lane multiply / dot-product-accumulate  |
// |               unit with valid/ready handshake and flush.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module simd_mac_unit
   import simd_mac_pkg::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned LANE_W        = 8,
   parameter int unsigned PIPE_STAGES   = 2,
   parameter int unsigned TRANS_ID_BITS = TRANS_ID_BITS_DEFAULT
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  simd_mac_op_t             op_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   input  logic [XLEN-1:0]          operand_a_i,
   input  logic [XLEN-1:0]          operand_b_i,
   input  logic [XLEN-1:0]          operand_c_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [XLEN-1:0]          result_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o
);

   localparam int unsigned N      = lane_count(XLEN, LANE_W);
   localparam int unsigned PROD_W = 2 * LANE_W;
   localparam int unsigned SUM_W  = sum_width(LANE_W, N);
   localparam int unsigned ACC_W  = (SUM_W > XLEN) ? SUM_W : XLEN;
   // With two or more stages the lane products are registered before the
   // adder tree; the remaining stages carry the finished result.
   localparam bit          RETIME     = (PIPE_STAGES > 1);
   localparam int          RES_STAGES = RETIME ? int'(PIPE_STAGES) - 1 : int'(PIPE_STAGES);

   // The whole pipe moves together; it only stops when the output is
   // holding a result the consumer has not taken.
   logic advance;
   assign ready_o = !valid_o || ready_i;
   assign advance = ready_o;

   // ------------------------------------------------------------------
   // Stage 0: decode and lane multipliers
   // ------------------------------------------------------------------
   simd_mac_ctrl_t ctrl_d;

   // Translate the opcode into per-operand signedness and result shape.
   always_comb begin
      ctrl_d = '0;
      case (op_i)
         SMULL:   ctrl_d = '{legal: 1'b1, mac: 1'b0, high: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
         UMULL:   ctrl_d = '{legal: 1'b1, mac: 1'b0, high: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
         SMULH:   ctrl_d = '{legal: 1'b1, mac: 1'b0, high: 1'b1, a_signed: 1'b1, b_signed: 1'b1};
         UMULH:   ctrl_d = '{legal: 1'b1, mac: 1'b0, high: 1'b1, a_signed: 1'b0, b_signed: 1'b0};
         SMAQA:   ctrl_d = '{legal: 1'b1, mac: 1'b1, high: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
         UMAQA:   ctrl_d = '{legal: 1'b1, mac: 1'b1, high: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
         SMAQASU: ctrl_d = '{legal: 1'b1, mac: 1'b1, high: 1'b0, a_signed: 1'b1, b_signed: 1'b0};
         default: ctrl_d = '0;
      endcase
   end

   logic [N-1:0][PROD_W-1:0] prod_d;

   for (genvar k = 0; k < int'(N); k++) begin : g_lane
      simd_mac_lane #(
         .LANE_W (LANE_W)
      ) u_lane (
         .a        (operand_a_i[k*LANE_W +: LANE_W]),
         .b        (operand_b_i[k*LANE_W +: LANE_W]),
         .a_signed (ctrl_d.a_signed),
         .b_signed (ctrl_d.b_signed),
         .product  (prod_d[k])
      );
   end

   // ------------------------------------------------------------------
   // Optional product register between multipliers and adder tree
   // ------------------------------------------------------------------
   logic                     mid_valid;
   simd_mac_ctrl_t           mid_ctrl;
   logic [N-1:0][PROD_W-1:0] mid_prod;
   logic [XLEN-1:0]          mid_c;
   logic [TRANS_ID_BITS-1:0] mid_tag;

   if (RETIME) begin : g_retime
      // Capture lane products, decoded op, accumulator and tag.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            mid_valid <= 1'b0;
            mid_ctrl  <= '0;
            mid_prod  <= '0;
            mid_c     <= '0;
            mid_tag   <= '0;
         end else begin
            if (flush_i) begin
               mid_valid <= 1'b0;
            end else if (advance) begin
               mid_valid <= valid_i;
            end
            if (advance && valid_i) begin
               mid_ctrl <= ctrl_d;
               mid_prod <= prod_d;
               mid_c    <= operand_c_i;
               mid_tag  <= trans_id_i;
            end
         end
      end
   end else begin : g_no_retime
      assign mid_valid = valid_i;
      assign mid_ctrl  = ctrl_d;
      assign mid_prod  = prod_d;
      assign mid_c     = operand_c_i;
      assign mid_tag   = trans_id_i;
   end

   // ------------------------------------------------------------------
   // Adder tree and result selection
   // ------------------------------------------------------------------
   logic             prod_signed;
   logic [SUM_W-1:0] lane_sum;
   logic [ACC_W-1:0] lane_sum_ext;
   logic [XLEN-1:0]  result_d;

   // Sum the lane products at SUM_W bits, widen, and pick the result.
   always_comb begin
      prod_signed  = mid_ctrl.a_signed | mid_ctrl.b_signed;
      lane_sum     = '0;
      for (int k = 0; k < int'(N); k++) begin
         lane_sum = lane_sum
                  + {{(SUM_W-PROD_W){prod_signed & mid_prod[k][PROD_W-1]}}, mid_prod[k]};
      end
      lane_sum_ext = ACC_W'(lane_sum);
      if (prod_signed && lane_sum[SUM_W-1]) begin
         lane_sum_ext = lane_sum_ext | ({ACC_W{1'b1}} << SUM_W);
      end
      result_d = '0;
      if (mid_ctrl.legal) begin
         if (mid_ctrl.mac) begin
            result_d = mid_c + lane_sum_ext[XLEN-1:0];
         end else if (mid_ctrl.high) begin
            result_d = mid_prod[N-1:N/2];
         end else begin
            result_d = mid_prod[N/2-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Result pipeline
   // ------------------------------------------------------------------
   logic [XLEN-1:0]          res_q [RES_STAGES];
   logic [TRANS_ID_BITS-1:0] tag_q [RES_STAGES];
   logic                     vld_q [RES_STAGES];

   // Shift results forward on the global enable; flush drops all valids.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RES_STAGES; i++) begin
            res_q[i] <= '0;
            tag_q[i] <= '0;
            vld_q[i] <= 1'b0;
         end
      end else begin
         if (flush_i) begin
            for (int i = 0; i < RES_STAGES; i++) begin
               vld_q[i] <= 1'b0;
            end
         end else if (advance) begin
            vld_q[0] <= mid_valid;
            for (int i = 1; i < RES_STAGES; i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
         if (advance) begin
            if (mid_valid) begin
               res_q[0] <= result_d;
               tag_q[0] <= mid_tag;
            end
            for (int i = 1; i < RES_STAGES; i++) begin
               if (vld_q[i-1]) begin
                  res_q[i] <= res_q[i-1];
                  tag_q[i] <= tag_q[i-1];
               end
            end
         end
      end
   end

   assign valid_o    = vld_q[RES_STAGES-1];
   assign result_o   = res_q[RES_STAGES-1];
   assign trans_id_o = tag_q[RES_STAGES-1];

endmodule
`default_nettype wire
